muldiv_unit: RTL
================

# muldiv_unit

- Multi-cycle multiply/divide unit for the pipelined MIPS core; sits in the Execute stage.
- Driven by the decoder's `start`, `MDop`, `HIwrite` and `LOwrite` signals, and by the Decode-stage `MD_yes` flag.
- Holds the HI/LO registers and models the fixed mult/div latencies with an internal counter.
- Generates the Decode-stage stall required while an HI/LO-touching instruction must wait for the unit.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy cycles for multu/mult/madd.
- `DIV_CYCLES`, default 10: busy cycles for divu/div.

Ports:
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: E-stage instruction is multu/mult/divu/div/madd.
- `MDop` input 3: operation select.
  - 000 multu, 001 mult, 010 divu, 011 div, 100 madd.
  - Any other value: no operation.
- `HIwrite` input 1: mthi in E stage; write `A` to HI.
- `LOwrite` input 1: mtlo in E stage; write `A` to LO.
- `A` input 32: forwarded GRF[rs] in E stage.
- `B` input 32: forwarded GRF[rt] in E stage.
- `D_MD_yes` input 1: D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo/madd.
- `busy` output 1: unit is computing.
- `HI` output 32: HI register.
- `LO` output 32: LO register.
- `MD_stall` output 1: freeze PC/IF-ID and insert a bubble into ID/EX.

## Operation

- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; a down-counter holds the remaining cycles.
- IDLE → RUN:
  - Occurs on a clock edge with `start`=1 and a valid `MDop`.
  - Latch `A`, `B`, `MDop`; load the counter with N−1, where N = MULT_CYCLES or DIV_CYCLES.
- RUN:
  - Decrement the counter each cycle.
  - On the edge where the counter is 0: commit the result to HI/LO and return to IDLE.
- Arithmetic; the 64-bit product is split HI=[63:32], LO=[31:0]:
  - multu: {HI,LO} = zero-extended A × B.
  - mult: {HI,LO} = signed A × B.
  - madd: {HI,LO} = {HI,LO} + signed A × B, modulo 2^64. The HI/LO values used are those current at commit.
  - divu: LO = A/B, HI = A%B (unsigned).
  - div: LO = quotient truncated toward zero; HI = remainder carrying the sign of A.
- Division by zero: still runs DIV_CYCLES busy cycles; HI and LO remain unchanged.
- `HIwrite`/`LOwrite`:
  - Act in IDLE only, on the next edge; HI/LO take `A`.
  - Ignored in RUN; the pipeline cannot present them then because `MD_stall` blocks them.
- Simultaneous requests:
  - `start` while RUN: ignored.
  - `start` together with `HIwrite` or `LOwrite`: `start` wins and the write is dropped.
- Stall: `MD_stall` = `D_MD_yes` & (`start` | `busy`). Purely combinational.
- mfhi/mflo read `HI`/`LO` directly; the stall guarantees these values are final.

## Timing

- Reset: `busy`=0, `HI`=0, `LO`=0, state IDLE, counter 0. Reset in RUN aborts the operation; no commit occurs.
- Latency, with `start` sampled on the edge ending cycle T:
  - `busy`=1 during cycles T+1 … T+N.
  - HI/LO take the new value on the edge ending T+N and are visible from T+N+1.
  - `busy`=0 at T+N+1.
- Back-to-back:
  - A new `start` may be accepted in the cycle `busy` first reads 0.
  - No idle gap is required.
- `MD_stall` is 1 in cycle T if `D_MD_yes`=1, and in cycles T+1 … T+N if `D_MD_yes`=1.
- mthi/mtlo results are visible one cycle after the E-stage cycle that issued them.

## Configuration

- Macro: `MULDIV_MADD_EN`.
- Defined:
  - MDop 100 performs madd as specified above.
  - Busy time is MULT_CYCLES.
- Undefined:
  - MDop 100 is treated as an invalid op; `start` is ignored.
  - `busy` stays 0 and HI/LO are unchanged.
  - `MD_stall` still follows the formula above.

## Test plan

- mult, A=0xFFFFFFFD, B=5: `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu on the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- div, A=0xFFFFFFF9 (−7), B=2: `busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, A=7, B=2 → LO=3, HI=1.
- divu, B=0 with prior HI=0x11, LO=0x22: 10 busy cycles, HI/LO unchanged.
- madd with `MULDIV_MADD_EN`:
  - Setup: mthi 0, mtlo 0xFFFFFFFF; then madd with A=2, B=3.
  - After 5 busy cycles: HI=0x00000001, LO=0x00000005.
  - Without the macro: `busy` stays 0 and HI/LO are unchanged.
- Stall and reset:
  - `D_MD_yes`=1 held across a mult: `MD_stall`=1 for 6 cycles (start cycle + 5).
  - `HIwrite` while `busy` is ignored.
  - `reset` pulsed at busy cycle 3 of a div: `busy`=0, HI=LO=0 immediately, with no later commit.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage of a pipelined MIPS core.
// Latency: busy for MULT_CYCLES (multu/mult/madd) or DIV_CYCLES (divu/div) cycles after the start edge.
// Backpressure: MD_stall freezes Decode while an HI/LO user waits on a pending or running op.
// The madd opcode (MDop 100) exists only when the MULDIV_MADD_EN macro is defined.
module muldiv_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDop,
   input  logic        HIwrite,
   input  logic        LOwrite,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        D_MD_yes,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        MD_stall
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULTU = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_DIVU  = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_MADD  = 3'b100;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;

   logic               op_valid;
   logic               op_is_mul;
   logic [63:0]        prod_u;
   logic [63:0]        prod_s;
   logic               div_zero;
   logic [31:0]        divisor;
   logic [31:0]        quo_u, rem_u;
   logic [31:0]        quo_s, rem_s;
`ifdef MULDIV_MADD_EN
   logic [63:0]        madd_sum;
`endif

   // Decode which opcodes launch an operation and which latency class they use
   always_comb begin
      op_valid  = 1'b0;
      op_is_mul = 1'b0;
      case (MDop)
         OP_MULTU, OP_MULT: begin op_valid = 1'b1; op_is_mul = 1'b1; end
         OP_DIVU, OP_DIV:   begin op_valid = 1'b1; op_is_mul = 1'b0; end
`ifdef MULDIV_MADD_EN
         OP_MADD:           begin op_valid = 1'b1; op_is_mul = 1'b1; end
`endif
         default:           begin op_valid = 1'b0; op_is_mul = 1'b0; end
      endcase
   end

   // Datapath on the latched operands; divisor is forced to 1 on zero so no X escapes (result is discarded then)
   always_comb begin
      prod_u   = {32'b0, a_q} * {32'b0, b_q};
      prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      div_zero = (b_q == 32'd0);
      divisor  = div_zero ? 32'd1 : b_q;
      quo_u    = a_q / divisor;
      rem_u    = a_q % divisor;
      quo_s    = $signed(a_q) / $signed(divisor);
      rem_s    = $signed(a_q) % $signed(divisor);
`ifdef MULDIV_MADD_EN
      madd_sum = {hi_q, lo_q} + prod_s;
`endif
   end

   // Next-state logic: launch from IDLE, count down in RUN, commit to HI/LO on the last busy cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start && op_valid) begin
               // an accepted start takes priority over a same-cycle mthi/mtlo
               state_d = S_RUN;
               op_d    = MDop;
               a_d     = A;
               b_d     = B;
               cnt_d   = op_is_mul ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
            end else begin
               if (HIwrite) hi_d = A;
               if (LOwrite) lo_d = A;
            end
         end
         S_RUN: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               case (op_q)
                  OP_MULTU: {hi_d, lo_d} = prod_u;
                  OP_MULT:  {hi_d, lo_d} = prod_s;
                  OP_DIVU: begin
                     if (!div_zero) begin
                        hi_d = rem_u;
                        lo_d = quo_u;
                     end
                  end
                  OP_DIV: begin
                     if (!div_zero) begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                     end
                  end
`ifdef MULDIV_MADD_EN
                  OP_MADD:  {hi_d, lo_d} = madd_sum;
`endif
                  default: begin
                     hi_d = hi_q;
                     lo_d = lo_q;
                  end
               endcase
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and HI/LO registers; reset aborts any running operation without committing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 3'b000;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy     = (state_q == S_RUN);
   assign HI       = hi_q;
   assign LO       = lo_q;
   assign MD_stall = D_MD_yes & (start | busy);

endmodule
